gcd_arbiter: RTL and testbench



---
 rtl/gcd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_gcd_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GCD engine among NUM_REQ requesters.
// Requesters are served in round-robin order. Zero-operand jobs bypass the
// engine. A watchdog aborts engine jobs that never complete. Each result is
// returned on a valid/ready port, tagged with the requester index.
module gcd_arbiter #(
  parameter int  NUM_REQ        = 4,
  parameter int  DATA_WIDTH     = 8,
  parameter int  TIMEOUT_CYCLES = 1023,
  localparam int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          nreset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_WIDTH-1:0]           rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_gcd_o,
  output logic                          rsp_err_o,
  output logic [DATA_WIDTH-1:0]         gcd_operand_a_o,
  output logic [DATA_WIDTH-1:0]         gcd_operand_b_o,
  output logic                          gcd_enable_o,
  input  logic                          gcd_done_i,
  input  logic [DATA_WIDTH-1:0]         gcd_result_i
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [ID_WIDTH-1:0]   r_last;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_err;
  logic                  r_rsp_valid;
  logic                  r_enable;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [ID_WIDTH-1:0]   w_cand;
  logic [ID_WIDTH-1:0]   w_gidx;
  logic                  w_hit;
  logic                  w_found;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;

  // Round-robin search: the first valid requester after the last one granted, with wrap-around
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    w_hit   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand  = ID_WIDTH'((int'(r_last) + off) % NUM_REQ);
      w_hit   = !w_found && req_valid_i[w_cand];
      w_gidx  = w_hit ? w_cand : w_gidx;
      w_found = w_found | w_hit;
    end
  end

  // Grant only in IDLE and out of reset; the grant is one-hot or zero
  always_comb begin
    w_grant = '0;
    if (w_found && (r_state == S_IDLE) && nreset_i) begin
      w_grant[w_gidx] = 1'b1;
    end else begin
      w_grant = '0;
    end
  end

  assign w_accept = |w_grant;
  assign w_a      = req_operand_a_i[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_b      = req_operand_b_i[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];

  // Control FSM: accept a job, run the engine under the watchdog, then hold the response
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      r_state     <= S_IDLE;
      r_last      <= ID_WIDTH'(NUM_REQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_enable    <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= w_a;
            r_b    <= w_b;
            r_id   <= w_gidx;
            r_last <= w_gidx;
            r_err  <= 1'b0;
            if ((w_a == '0) || (w_b == '0)) begin
              // gcd(x,0)=x and gcd(0,0)=0 are both just the OR of the operands
              r_result    <= w_a | w_b;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_cnt    <= '0;
              r_enable <= 1'b1;
              r_state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // A done in the final watchdog cycle still counts as success
          if (gcd_done_i) begin
            r_result    <= gcd_result_i;
            r_err       <= 1'b0;
            r_enable    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            r_result    <= '0;
            r_err       <= 1'b1;
            r_enable    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_enable    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o     = w_grant;
  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_id_o        = r_id;
  assign rsp_gcd_o       = r_result;
  assign rsp_err_o       = r_err;
  assign gcd_operand_a_o = r_a;
  assign gcd_operand_b_o = r_b;
  assign gcd_enable_o    = r_enable;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed and randomized checks of gcd_arbiter.
// The bench plays the GCD engine itself. A small round-robin and Euclid
// reference model provides the expected values.
module tb_gcd_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              nreset_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*DW-1:0]  req_operand_a_i;
  logic [NR*DW-1:0]  req_operand_b_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [IW-1:0]     rsp_id_o;
  logic [DW-1:0]     rsp_gcd_o;
  logic              rsp_err_o;
  logic [DW-1:0]     gcd_operand_a_o;
  logic [DW-1:0]     gcd_operand_b_o;
  logic              gcd_enable_o;
  logic              gcd_done_i;
  logic [DW-1:0]     gcd_result_i;

  int total = 0;
  int bad   = 0;
  int m_last;
  logic [DW-1:0] opa [NR];
  logic [DW-1:0] opb [NR];

  // Free-running clock
  always #5 clk = ~clk;

  gcd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .nreset_i(nreset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operand_a_i(req_operand_a_i), .req_operand_b_i(req_operand_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_gcd_o(rsp_gcd_o), .rsp_err_o(rsp_err_o),
    .gcd_operand_a_o(gcd_operand_a_o), .gcd_operand_b_o(gcd_operand_b_o),
    .gcd_enable_o(gcd_enable_o), .gcd_done_i(gcd_done_i), .gcd_result_i(gcd_result_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] gcd_ref(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int p = x;
    int q = y;
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return DW'(p);
  endfunction

  function automatic int pick(input logic [NR-1:0] v);
    for (int o = 1; o <= NR; o++) begin
      if (v[(m_last + o) % NR]) return (m_last + o) % NR;
    end
    return -1;
  endfunction

  task automatic drive_ops();
    for (int k = 0; k < NR; k++) begin
      req_operand_a_i[k*DW +: DW] = opa[k];
      req_operand_b_i[k*DW +: DW] = opb[k];
    end
  endtask

  // One complete job. Engine done comes in enable cycle 'lat' (never if lat<1 or lat>TO).
  // The response is held off for 'bp' cycles before it is accepted.
  task automatic run_job(input logic [NR-1:0] v, input int lat, input int bp);
    int g;
    logic [DW-1:0] a, b, ex;
    logic exerr;
    bit done_now;
    drive_ops();
    rsp_ready_i = 1'b0;
    req_valid_i = v;
    #1;
    g = pick(v);
    chk("idle_rsp_valid", rsp_valid_o, 32'd0);
    chk("idle_enable", gcd_enable_o, 32'd0);
    chk("grant", req_ready_o, 32'd1 << g);
    a = opa[g];
    b = opb[g];
    m_last = g;
    @(posedge clk); #1;
    if (a == '0 || b == '0) begin
      ex = a | b;
      exerr = 1'b0;
    end else begin
      ex = '0;
      exerr = 1'b1;
      for (int n = 1; n <= TO; n++) begin
        chk("busy_enable", gcd_enable_o, 32'd1);
        chk("busy_op_a", gcd_operand_a_o, a);
        chk("busy_op_b", gcd_operand_b_o, b);
        chk("busy_ready", req_ready_o, 32'd0);
        chk("busy_rsp_valid", rsp_valid_o, 32'd0);
        done_now = (n == lat);
        gcd_done_i = done_now;
        gcd_result_i = done_now ? gcd_ref(a, b) : DW'($urandom);
        @(posedge clk); #1;
        gcd_done_i = 1'b0;
        if (done_now) begin
          ex = gcd_ref(a, b);
          exerr = 1'b0;
          break;
        end
      end
    end
    for (int c = 0; c <= bp; c++) begin
      chk("rsp_valid", rsp_valid_o, 32'd1);
      chk("rsp_id", rsp_id_o, g);
      chk("rsp_gcd", rsp_gcd_o, ex);
      chk("rsp_err", rsp_err_o, exerr);
      chk("rsp_enable", gcd_enable_o, 32'd0);
      chk("rsp_ready_out", req_ready_o, 32'd0);
      chk("rsp_op_a", gcd_operand_a_o, a);
      chk("rsp_op_b", gcd_operand_b_o, b);
      rsp_ready_i  = (c == bp);
      gcd_done_i   = 1'b1;
      gcd_result_i = DW'($urandom);
      @(posedge clk); #1;
    end
    rsp_ready_i = 1'b0;
    gcd_done_i  = 1'b0;
  endtask

  initial begin
    nreset_i = 1'b0;
    req_valid_i = '1;
    rsp_ready_i = 1'b0;
    gcd_done_i = 1'b0;
    gcd_result_i = '0;
    for (int k = 0; k < NR; k++) begin
      opa[k] = '0;
      opb[k] = '0;
    end
    drive_ops();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", req_ready_o, 32'd0);
    chk("reset_rsp_valid", rsp_valid_o, 32'd0);
    chk("reset_enable", gcd_enable_o, 32'd0);
    chk("reset_gcd", rsp_gcd_o, 32'd0);
    chk("reset_id", rsp_id_o, 32'd0);
    chk("reset_err", rsp_err_o, 32'd0);
    chk("reset_op_a", gcd_operand_a_o, 32'd0);
    chk("reset_op_b", gcd_operand_b_o, 32'd0);
    req_valid_i = '0;
    nreset_i = 1'b1;
    m_last = NR - 1;
    @(posedge clk); #1;

    // Round-robin fairness: order 0,1,2,3,0, then 2,3,0,2 with requester 1 dropped
    for (int k = 0; k < NR; k++) begin
      opa[k] = DW'(12 * (k + 1));
      opb[k] = DW'(8);
    end
    repeat (5) run_job(4'b1111, 2, 0);
    repeat (4) run_job(4'b1101, 3, 0);

    // Single request from requester 2
    opa[2] = 8'd48;
    opb[2] = 8'd18;
    run_job(4'b0100, 5, 0);

    // Zero bypass
    opa[1] = 8'd0;  opb[1] = 8'd9;  run_job(4'b0010, 3, 0);
    opa[1] = 8'd12; opb[1] = 8'd0;  run_job(4'b0010, 3, 0);
    opa[1] = 8'd0;  opb[1] = 8'd0;  run_job(4'b0010, 3, 0);

    // Response backpressure
    opa[0] = 8'd100; opb[0] = 8'd75;
    run_job(4'b0001, 3, 5);
    run_job(4'b0001, 0, 5);

    // Watchdog: never done, done in the last cycle, done one cycle earlier
    opa[3] = 8'd91; opb[3] = 8'd35;
    run_job(4'b1000, -1, 0);
    run_job(4'b1000, TO, 0);
    run_job(4'b1000, TO - 1, 1);

    // Reset in the middle of an engine job
    opa[3] = 8'd30; opb[3] = 8'd12;
    drive_ops();
    req_valid_i = 4'b1000;
    #1;
    chk("rst_job_grant", req_ready_o, 32'h8);
    @(posedge clk); #1;
    req_valid_i = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("rst_job_busy", gcd_enable_o, 32'd1);
    nreset_i = 1'b0;
    @(posedge clk); #1;
    nreset_i = 1'b1;
    m_last = NR - 1;
    chk("midrst_enable", gcd_enable_o, 32'd0);
    chk("midrst_rsp_valid", rsp_valid_o, 32'd0);
    chk("midrst_op_a", gcd_operand_a_o, 32'd0);
    repeat (3) begin
      gcd_done_i = 1'b1;
      gcd_result_i = 8'd6;
      @(posedge clk); #1;
      chk("midrst_no_rsp", rsp_valid_o, 32'd0);
      chk("midrst_no_enable", gcd_enable_o, 32'd0);
    end
    gcd_done_i = 1'b0;
    run_job(4'b1111, 2, 0);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      int r;
      logic [NR-1:0] v;
      for (int k = 0; k < NR; k++) begin
        opa[k] = ($urandom_range(3) == 0) ? '0 : DW'($urandom);
        opb[k] = ($urandom_range(3) == 0) ? '0 : DW'($urandom);
      end
      v = NR'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      run_job(v, (r == 0) ? -1 : r, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
